// File: rtl/sr_stage.sv
// Write-back stage: selects the result value, derives NZP, gates register/CC
// enables with the valid bit, and holds the architectural CC and retire count.
module sr_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        sr_v,
    input  logic [15:0] sr_ir,
    input  logic [15:0] sr_npc,
    input  logic [15:0] sr_address,
    input  logic [15:0] sr_alu_result,
    input  logic [15:0] sr_data,
    input  logic [2:0]  sr_drid,
    input  logic [3:0]  sr_cs,
    output logic        v_sr_ld_reg,
    output logic        v_sr_ld_cc,
    output logic [2:0]  sr_drid_out,
    output logic [15:0] sr_reg_data,
    output logic [2:0]  sr_cc_data,
    output logic [2:0]  cc_q,
    output logic [31:0] retired_cnt
);

    localparam int unsigned DATA_W = 16;
    localparam int unsigned CC_W   = 3;
    localparam int unsigned CNT_W  = 32;

    localparam logic [CC_W-1:0] CC_N = 3'b100;
    localparam logic [CC_W-1:0] CC_Z = 3'b010;
    localparam logic [CC_W-1:0] CC_P = 3'b001;

    localparam logic [1:0] SEL_ADDRESS = 2'b00;
    localparam logic [1:0] SEL_DATA    = 2'b01;
    localparam logic [1:0] SEL_NPC     = 2'b10;

    // The instruction word travels with the latch for tracing only.
    logic unused_ir;
    assign unused_ir = ^sr_ir;

    // Write-back value mux (DR.VALUEMUX).
    always_comb begin
        sr_reg_data = sr_alu_result;
        case (sr_cs[1:0])
            SEL_ADDRESS: sr_reg_data = sr_address;
            SEL_DATA:    sr_reg_data = sr_data;
            SEL_NPC:     sr_reg_data = sr_npc;
            default:     sr_reg_data = sr_alu_result;
        endcase
    end

    // NZP is one-hot; the sign bit takes priority over the zero test.
    always_comb begin
        sr_cc_data = CC_P;
        if (sr_reg_data[DATA_W-1])
            sr_cc_data = CC_N;
        else if (sr_reg_data == DATA_W'(0))
            sr_cc_data = CC_Z;
    end

    assign v_sr_ld_reg = sr_v & sr_cs[2];
    assign v_sr_ld_cc  = sr_v & sr_cs[3];
    assign sr_drid_out = sr_drid;

    // Architectural state; reset dominates load and increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            cc_q        <= CC_Z;
            retired_cnt <= CNT_W'(0);
        end else begin
            if (v_sr_ld_cc)
                cc_q <= sr_cc_data;
            if (sr_v)
                retired_cnt <= retired_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_sr_stage.sv
// Directed plus randomized bench for sr_stage against a behavioural model.
module tb_sr_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        sr_v;
    logic [15:0] sr_ir, sr_npc, sr_address, sr_alu_result, sr_data;
    logic [2:0]  sr_drid;
    logic [3:0]  sr_cs;
    logic        v_sr_ld_reg, v_sr_ld_cc;
    logic [2:0]  sr_drid_out, sr_cc_data, cc_q;
    logic [15:0] sr_reg_data;
    logic [31:0] retired_cnt;

    int vectors = 0;
    int miscompares = 0;

    logic [2:0]  m_cc;
    logic [31:0] m_cnt;

    sr_stage dut (
        .clk(clk), .rst(rst), .sr_v(sr_v), .sr_ir(sr_ir), .sr_npc(sr_npc),
        .sr_address(sr_address), .sr_alu_result(sr_alu_result),
        .sr_data(sr_data), .sr_drid(sr_drid), .sr_cs(sr_cs),
        .v_sr_ld_reg(v_sr_ld_reg), .v_sr_ld_cc(v_sr_ld_cc),
        .sr_drid_out(sr_drid_out), .sr_reg_data(sr_reg_data),
        .sr_cc_data(sr_cc_data), .cc_q(cc_q), .retired_cnt(retired_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] ref_value();
        case (sr_cs[1:0])
            2'd0:    return sr_address;
            2'd1:    return sr_data;
            2'd2:    return sr_npc;
            default: return sr_alu_result;
        endcase
    endfunction

    function automatic logic [2:0] ref_nzp(input logic [15:0] val);
        if ($signed(val) < 0) return 3'b100;
        if (val == 16'd0)     return 3'b010;
        return 3'b001;
    endfunction

    task automatic drive(input logic r, input logic v, input logic [3:0] cs,
                         input logic [15:0] addr, input logic [15:0] dat,
                         input logic [15:0] npc, input logic [15:0] alu,
                         input logic [2:0] drid);
        rst = r; sr_v = v; sr_cs = cs; sr_address = addr; sr_data = dat;
        sr_npc = npc; sr_alu_result = alu; sr_drid = drid;
        sr_ir = 16'($urandom);
    endtask

    // Check combinational outputs, then clock once and check architectural state.
    task automatic step(input bit check_regs);
        logic [15:0] val;
        #1;
        val = ref_value();
        chk("reg_data", 32'(sr_reg_data), 32'(val));
        chk("cc_data", 32'(sr_cc_data), 32'(ref_nzp(val)));
        chk("ld_reg", 32'(v_sr_ld_reg), 32'(sr_v && sr_cs[2]));
        chk("ld_cc", 32'(v_sr_ld_cc), 32'(sr_v && sr_cs[3]));
        chk("drid_out", 32'(sr_drid_out), 32'(sr_drid));
        if (rst) begin
            m_cc = 3'b010;
            m_cnt = 0;
        end else begin
            if (sr_v && sr_cs[3]) m_cc = ref_nzp(val);
            if (sr_v) m_cnt = m_cnt + 1;
        end
        @(posedge clk);
        #1;
        if (check_regs) begin
            chk("cc_q", 32'(cc_q), 32'(m_cc));
            chk("retired_cnt", retired_cnt, m_cnt);
        end
    endtask

    initial begin
        m_cc = 3'b010;
        m_cnt = 0;
        drive(1, 0, 4'b0000, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        chk("rst_cc_q", 32'(cc_q), 32'(3'b010));
        chk("rst_cnt", retired_cnt, 32'd0);

        // Value mux and NZP cases.
        drive(0, 1, 4'b1100, 16'h1234, 16'h5555, 16'h7777, 16'h9999, 3'd5); step(1);
        drive(0, 1, 4'b1101, 16'h0000, 16'h8001, 16'h7777, 16'h9999, 3'd5); step(1);
        drive(0, 1, 4'b1110, 16'h0001, 16'h8001, 16'h0000, 16'h9999, 3'd5); step(1);
        drive(0, 1, 4'b1111, 16'h0001, 16'h8001, 16'h0001, 16'hBEEF, 3'd5); step(1);

        // Bubble and no-enable cases must not touch CC; bubble must not count.
        drive(0, 0, 4'b1100, 16'h0000, 0, 0, 0, 3'd5); step(1);
        drive(0, 1, 4'b0000, 16'h0000, 0, 0, 0, 3'd5); step(1);

        // Reset, then one CC-loading instruction.
        drive(1, 0, 4'b0000, 0, 0, 0, 0, 3'd5); step(1);
        drive(0, 1, 4'b1111, 0, 0, 0, 16'hBEEF, 3'd5); step(1);

        // Three valid edges without LD.CC, then a bubble.
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 4'b0111, 0, 0, 0, 16'h0042, 3'(i)); step(1);
        end
        drive(0, 0, 4'b1111, 0, 0, 0, 0, 3'd2); step(1);

        // Reset on the same edge as a CC load.
        drive(1, 1, 4'b1111, 0, 0, 0, 16'h0003, 3'd1); step(1);

        // Randomized traffic with occasional resets and forced zero operands.
        for (int i = 0; i < 300; i++) begin
            drive(($urandom_range(0, 19) == 0), 1'($urandom), 4'($urandom),
                  ($urandom_range(0, 5) == 0) ? 16'h0 : 16'($urandom),
                  ($urandom_range(0, 5) == 0) ? 16'h0 : 16'($urandom),
                  ($urandom_range(0, 5) == 0) ? 16'h0 : 16'($urandom),
                  ($urandom_range(0, 5) == 0) ? 16'h0 : 16'($urandom),
                  3'($urandom));
            step(1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
